// File: rtl/vga_board_fetch.sv
// vga_board_fetch: copies the game board from shared memory into a double-buffered shadow bank during vblank.
module vga_board_fetch #(
    parameter int              ADDR_W       = 12,
    parameter int              DATA_W       = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 12'd2048,
    parameter int              NUM_CELLS    = 42,
    parameter int              STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vsync,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_grant,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [5:0]        cell_idx,
    output logic [DATA_W-1:0] cell_data,
    output logic              frame_valid,
    output logic              fetch_busy
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(STARVE_LIMIT);
    localparam logic [5:0] LAST = 6'(NUM_CELLS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t state, state_nx;

    logic              vsync_d, front, rd_vld;
    logic [5:0]        issue_idx, rd_idx;
    logic [SW-1:0]     stall_cnt;
    logic [DATA_W-1:0] bank [2][NUM_CELLS];
    logic              fall, rise, force_slot, fetch_own, last_capture, swap;

    assign fall         = vsync_d & ~vsync;
    assign rise         = ~vsync_d & vsync;
    assign force_slot   = (state == FETCH) && (stall_cnt == STALL_MAX);
    assign fetch_own    = (state == FETCH) && (!cpu_req || force_slot);
    assign last_capture = rd_vld && (rd_idx == LAST);
    assign swap         = (state == DRAIN) && last_capture && !rise;

    // CPU wins every contested cycle except the forced starvation slot
    assign cpu_grant = cpu_req && !force_slot;
    assign mem_addr  = cpu_grant ? cpu_addr : fetch_own ? BASE_ADDR + ADDR_W'(issue_idx) : BASE_ADDR;
    assign mem_we    = cpu_grant && cpu_we;
    assign mem_wdata = cpu_grant ? cpu_wdata : '0;
    assign cell_data = (cell_idx < 6'(NUM_CELLS)) ? bank[front][cell_idx] : '0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = fall ? FETCH : IDLE;
            FETCH:   state_nx = rise ? IDLE : (fetch_own && issue_idx == LAST) ? DRAIN : FETCH;
            DRAIN:   state_nx = (rise || last_capture) ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            vsync_d     <= 1'b1;
            front       <= 1'b0;
            frame_valid <= 1'b0;
            fetch_busy  <= 1'b0;
            issue_idx   <= '0;
            rd_idx      <= '0;
            rd_vld      <= 1'b0;
            stall_cnt   <= '0;
            for (int i = 0; i < NUM_CELLS; i++) begin
                bank[0][i] <= '0;
                bank[1][i] <= '0;
            end
        end else begin
            state      <= state_nx;
            vsync_d    <= vsync;
            fetch_busy <= state_nx != IDLE;
            issue_idx  <= (state != FETCH) ? '0 : fetch_own ? issue_idx + 6'd1 : issue_idx;
            stall_cnt  <= (state != FETCH || fetch_own || !cpu_req) ? '0 : stall_cnt + 1'b1;
            // an abort cancels the read issued in the same cycle
            rd_vld     <= fetch_own && !rise;
            rd_idx     <= issue_idx;
            if (rd_vld)
                bank[~front][rd_idx] <= mem_rdata;
            if (swap) begin
                front       <= ~front;
                frame_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vga_board_fetch.sv
// tb_vga_board_fetch: randomized and directed checks of the board fetcher against a cycle-level arbitration model.
module tb_vga_board_fetch;
    localparam int N = 42;
    localparam logic [11:0] BASE = 12'd2048;

    logic        clk = 0, reset = 1, vsync = 1, cpu_req = 0, cpu_we = 0;
    logic [11:0] cpu_addr = '0, mem_addr;
    logic [15:0] cpu_wdata = '0, mem_wdata, mem_rdata, cell_data;
    logic [5:0]  cell_idx = '0;
    logic        cpu_grant, mem_we, frame_valid, fetch_busy;

    logic [15:0] mem [4096];
    logic [15:0] model_mem [4096];
    logic [15:0] front_exp [N];
    bit          fv_exp;
    bit          req_p [600];
    bit          we_p [600];
    logic [11:0] addr_p [600];
    logic [15:0] data_p [600];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    vga_board_fetch dut (
        .clk(clk), .reset(reset), .vsync(vsync),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_grant(cpu_grant), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .cell_idx(cell_idx), .cell_data(cell_data),
        .frame_valid(frame_valid), .fetch_busy(fetch_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    endtask

    task automatic clear_pattern();
        for (int c = 0; c < 600; c++) begin
            req_p[c] = 0; we_p[c] = 0; addr_p[c] = '0; data_p[c] = '0;
        end
    endtask

    task automatic check_cells(input string name);
        logic [15:0] e;
        for (int i = 0; i < 64; i++) begin
            cell_idx = 6'(i);
            #1;
            e = (i < N) ? front_exp[i] : 16'h0000;
            checks++;
            if (cell_data !== e) begin
                errors++;
                $display("FAIL %s idx %0d got %h exp %h", name, i, cell_data, e);
            end
        end
    endtask

    task automatic preload(input logic [15:0] base, input bit rnd);
        for (int k = 0; k < N; k++) begin
            tick();
            cpu_req = 1; cpu_we = 1; cpu_addr = BASE + 12'(k);
            cpu_wdata = rnd ? 16'($urandom) : base + 16'(k);
            model_mem[cpu_addr] = cpu_wdata;
            @(negedge clk);
            checks++;
            if (cpu_grant !== 1'b1 || mem_addr !== cpu_addr || mem_we !== 1'b1) begin
                errors++;
                $display("FAIL preload_grant k %0d got grant %b addr %h we %b", k, cpu_grant, mem_addr, mem_we);
            end
        end
        tick();
        idle();
    endtask

    // Drives one vsync fall and follows the fetch cycle by cycle against the arbitration rules.
    task automatic run_frame(input int abort_at, output int done_c);
        logic [15:0] snap [N];
        logic [11:0] ea;
        int k, stall, last_c;
        bit ab, in_f, frc, own, g, busy, ew;
        k = 0; stall = 0; last_c = -10; ab = 0; done_c = 0;
        tick();
        idle();
        vsync = 0;
        @(negedge clk);
        checks++;
        if (fetch_busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_cycle0 got %b exp 0", fetch_busy);
        end
        for (int c = 1; c < 600; c++) begin
            tick();
            cpu_req = req_p[c]; cpu_we = we_p[c]; cpu_addr = addr_p[c]; cpu_wdata = data_p[c];
            vsync = (abort_at > 0 && c >= abort_at);
            @(negedge clk);
            in_f = !ab && k < N;
            frc  = in_f && stall == 4;
            own  = in_f && (!cpu_req || frc);
            g    = cpu_req && !frc;
            busy = !ab && (k < N || c == last_c + 1);
            ea   = own ? BASE + 12'(k) : g ? addr_p[c] : BASE;
            ew   = g && we_p[c];
            checks++;
            if (cpu_grant !== g) begin
                errors++;
                $display("FAIL grant cycle %0d got %b exp %b", c, cpu_grant, g);
            end
            checks++;
            if (mem_addr !== ea || mem_we !== ew) begin
                errors++;
                $display("FAIL port cycle %0d got addr %h we %b exp addr %h we %b", c, mem_addr, mem_we, ea, ew);
            end
            checks++;
            if (fetch_busy !== busy) begin
                errors++;
                $display("FAIL busy cycle %0d got %b exp %b", c, fetch_busy, busy);
            end
            if (own) begin
                snap[k] = model_mem[BASE + 12'(k)];
                k++;
                stall = 0;
                if (k == N) last_c = c;
            end else if (in_f) stall++;
            if (ew) model_mem[addr_p[c]] = data_p[c];
            if (c == abort_at) ab = 1;
            if (!busy) begin
                checks++;
                if (frame_valid !== (ab ? fv_exp : 1'b1)) begin
                    errors++;
                    $display("FAIL valid_at_done got %b exp %b", frame_valid, ab ? fv_exp : 1'b1);
                end
                done_c = c;
                break;
            end
        end
        idle();
        checks++;
        if (done_c == 0) begin
            errors++;
            $display("FAIL frame_timeout got busy %b exp 0", fetch_busy);
        end else if (!ab) begin
            for (int i = 0; i < N; i++) front_exp[i] = snap[i];
            fv_exp = 1;
        end
        tick();
        vsync = 1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (frame_valid !== fv_exp) begin
            errors++;
            $display("FAIL frame_valid got %b exp %b", frame_valid, fv_exp);
        end
        check_cells("frame_cells");
    endtask

    task automatic test_reset();
        reset = 1; vsync = 1;
        idle();
        repeat (3) tick();
        @(negedge clk);
        for (int i = 0; i < N; i++) front_exp[i] = '0;
        fv_exp = 0;
        checks++;
        if (frame_valid !== 1'b0 || fetch_busy !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got valid %b busy %b we %b exp 0 0 0", frame_valid, fetch_busy, mem_we);
        end
        check_cells("reset_cells");
        tick();
        reset = 0;
        tick();
    endtask

    task automatic test_basic_fetch();
        int d;
        preload(16'hA000, 0);
        clear_pattern();
        run_frame(0, d);
        checks++;
        if (d != 44) begin
            errors++;
            $display("FAIL basic_done_cycle got %0d exp 44", d);
        end
    endtask

    task automatic test_starve();
        int d;
        preload(16'hB000, 0);
        clear_pattern();
        for (int c = 1; c < 600; c++) begin
            req_p[c] = 1;
            addr_p[c] = 12'($urandom_range(0, 2047));
        end
        run_frame(0, d);
        checks++;
        if (d != 212) begin
            errors++;
            $display("FAIL starve_done_cycle got %0d exp 212", d);
        end
    endtask

    task automatic test_abort();
        int d;
        preload(16'hC000, 0);
        clear_pattern();
        run_frame(21, d);
        checks++;
        if (d != 22) begin
            errors++;
            $display("FAIL abort_done_cycle got %0d exp 22", d);
        end
        cell_idx = 6'd5;
        #1;
        checks++;
        if (cell_data !== 16'hB005) begin
            errors++;
            $display("FAIL abort_old_frame got %h exp b005", cell_data);
        end
    endtask

    task automatic test_coherency();
        int d;
        preload(16'hD000, 0);
        clear_pattern();
        req_p[5] = 1;  we_p[5] = 1;  addr_p[5] = 12'd2089;  data_p[5] = 16'h0001;
        req_p[10] = 1; we_p[10] = 1; addr_p[10] = 12'd2050; data_p[10] = 16'h0002;
        req_p[15] = 1; we_p[15] = 1; addr_p[15] = 12'd2060; data_p[15] = 16'h0003;
        run_frame(0, d);
        cell_idx = 6'd41;
        #1;
        checks++;
        if (cell_data !== 16'h0001) begin
            errors++;
            $display("FAIL coh_early_write got %h exp 0001", cell_data);
        end
        cell_idx = 6'd2;
        #1;
        checks++;
        if (cell_data !== 16'hD002) begin
            errors++;
            $display("FAIL coh_late_write got %h exp d002", cell_data);
        end
        cell_idx = 6'd12;
        #1;
        checks++;
        if (cell_data !== 16'h0003) begin
            errors++;
            $display("FAIL coh_same_cycle got %h exp 0003", cell_data);
        end
    endtask

    task automatic test_random();
        int d, thr;
        for (int r = 0; r < 4; r++) begin
            preload(16'h0000, 1);
            clear_pattern();
            thr = $urandom_range(20, 90);
            for (int c = 1; c < 600; c++) begin
                req_p[c]  = $urandom_range(0, 99) < thr;
                we_p[c]   = 1'($urandom_range(0, 1));
                addr_p[c] = BASE + 12'($urandom_range(0, 45));
                data_p[c] = 16'($urandom);
            end
            run_frame(0, d);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int d;
        preload(16'hE000, 0);
        tick();
        vsync = 0;
        repeat (30) tick();
        reset = 1;
        vsync = 1;
        repeat (2) tick();
        @(negedge clk);
        for (int i = 0; i < N; i++) front_exp[i] = '0;
        fv_exp = 0;
        checks++;
        if (frame_valid !== 1'b0 || fetch_busy !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL midreset_flags got valid %b busy %b we %b exp 0 0 0", frame_valid, fetch_busy, mem_we);
        end
        check_cells("midreset_cells");
        tick();
        reset = 0;
        tick();
        clear_pattern();
        run_frame(0, d);
        checks++;
        if (d != 44) begin
            errors++;
            $display("FAIL midreset_refetch_done got %0d exp 44", d);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_starve();
        test_abort();
        test_coherency();
        test_random();
        test_reset_mid_fetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got running exp finished");
        $fatal(1);
    end
endmodule
